// File: rtl/ram_pkg.sv
// Shared types and helpers for the byte-enabled dual-port RAM.
package ram_pkg;

  // Sweep state: CLEAR zeroes the array after reset, READY serves requests.
  typedef enum logic [0:0] {
    RAM_CLEAR = 1'b0,
    RAM_READY = 1'b1
  } ram_state_e;

  // Upper bound on word width handled by the generic merge helper.
  localparam int MAX_DW   = 256;
  localparam int MAX_NB   = 256;
  localparam int MAX_DW_W = $clog2(MAX_DW);
  localparam int MAX_NB_W = $clog2(MAX_NB);

  function automatic int num_bytes(input int dw, input int bw);
    return dw / bw;
  endfunction

  // Lane merge: lanes with be set take new_w, the rest keep old_w.
  // Callers zero-extend into MAX_DW and cast the result back down.
  function automatic logic [MAX_DW-1:0] be_merge(input logic [MAX_DW-1:0] old_w,
                                                 input logic [MAX_DW-1:0] new_w,
                                                 input logic [MAX_NB-1:0] be,
                                                 input int                bw);
    logic [MAX_DW-1:0] m;
    m = old_w;
    for (int i = 0; i < MAX_DW; i++) begin
      if (be[MAX_NB_W'(i / bw)]) m[MAX_DW_W'(i)] = new_w[MAX_DW_W'(i)];
    end
    return m;
  endfunction

endpackage

// File: rtl/ram_init_sweep.sv
// Post-reset clear sweep: walks addresses 0..MEMORY_DEPTH-1 writing zero,
// then parks in READY until the next reset.
module ram_init_sweep import ram_pkg::*; #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int MEMORY_DEPTH  = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  output logic                     clear_en_o,
  output logic [ADDRESS_WIDTH-1:0] clear_addr_o,
  output logic                     ready_o
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(MEMORY_DEPTH - 1);

  ram_state_e               state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d;

  // Advance the sweep one word per cycle; leave CLEAR after the last word.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == RAM_CLEAR) begin
      if (cnt_q == LAST_ADDR) state_d = RAM_READY;
      else                    cnt_d   = cnt_q + 1'b1;
    end
  end

  // State and counter registers, restart the sweep on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RAM_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign clear_en_o   = (state_q == RAM_CLEAR);
  assign clear_addr_o = cnt_q;
  assign ready_o      = (state_q == RAM_READY);

endmodule

// File: rtl/ram_dp_be.sv
// Simple dual-port RAM (one write port, one read port) with per-byte write
// enables, post-reset clear sweep, read-valid strobe and range error flag.
// Optional macro RAM_BYPASS_EN: same-cycle same-address read returns the
// lane-merged write data instead of the old stored word.
module ram_dp_be import ram_pkg::*; #(
  parameter  int ADDRESS_WIDTH = 5,
  parameter  int DATA_WIDTH    = 32,
  parameter  int BYTE_WIDTH    = 8,
  parameter  int MEMORY_DEPTH  = 32,
  localparam int NUM_BYTES     = num_bytes(DATA_WIDTH, BYTE_WIDTH)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  output logic                     ready_o,
  input  logic                     wr_en_i,
  input  logic [ADDRESS_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0]    wr_data_i,
  input  logic [NUM_BYTES-1:0]     wr_be_i,
  input  logic                     rd_en_i,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0]    rd_data_o,
  output logic                     rd_valid_o,
  output logic                     err_o
);

  localparam logic [ADDRESS_WIDTH:0] DEPTH_C = (ADDRESS_WIDTH + 1)'(MEMORY_DEPTH);

  logic                     clear_en, ready;
  logic [ADDRESS_WIDTH-1:0] clear_addr;

  ram_init_sweep #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .MEMORY_DEPTH (MEMORY_DEPTH)
  ) u_sweep (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_en_o  (clear_en),
    .clear_addr_o(clear_addr),
    .ready_o     (ready)
  );

  logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

  logic                     wr_in, rd_in, wr_ok, rd_ok;
  logic [DATA_WIDTH-1:0]    wr_old, wr_merged, mem_rd, rd_word;
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic [DATA_WIDTH-1:0]    rd_data_q, rd_data_d;
  logic                     rd_valid_q, rd_valid_d;
  logic                     err_q, err_d;

  // Range checks, request qualification and the write-port mux
  // (sweep owns the port while clearing, requests are ignored then).
  always_comb begin
    wr_in     = ({1'b0, wr_addr_i} < DEPTH_C);
    rd_in     = ({1'b0, rd_addr_i} < DEPTH_C);
    wr_ok     = ready & wr_en_i & wr_in;
    rd_ok     = ready & rd_en_i;
    wr_old    = wr_in ? mem[wr_addr_i] : '0;
    mem_rd    = rd_in ? mem[rd_addr_i] : '0;
    wr_merged = DATA_WIDTH'(be_merge(MAX_DW'(wr_old), MAX_DW'(wr_data_i),
                                     MAX_NB'(wr_be_i), BYTE_WIDTH));
    mem_we    = clear_en | wr_ok;
    mem_waddr = clear_en ? clear_addr : wr_addr_i;
    mem_wdata = clear_en ? '0 : wr_merged;
  end

  // Read-side next state; out-of-range reads load zero via mem_rd.
  always_comb begin
`ifdef RAM_BYPASS_EN
    rd_word = (wr_ok && (wr_addr_i == rd_addr_i)) ? wr_merged : mem_rd;
`else
    rd_word = mem_rd;
`endif
    rd_data_d  = rd_ok ? rd_word : rd_data_q;
    rd_valid_d = rd_ok;
    err_d      = ready & ((wr_en_i & ~wr_in) | (rd_en_i & ~rd_in));
  end

  // Storage array: no reset, contents come from the sweep.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  assign ready_o    = ready;
  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_ram_dp_be.sv
// Self-checking bench for ram_dp_be: default instance (depth 32) plus a
// depth-20 instance for out-of-range behaviour.
module tb_ram_dp_be;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          ready, wr_en, rd_en, rd_valid, err;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data, rd_data;
  logic [NB-1:0] wr_be;

  logic          ready2, wr_en2, rd_en2, rd_valid2, err2;
  logic [AW-1:0] wr_addr2, rd_addr2;
  logic [DW-1:0] wr_data2, rd_data2;
  logic [NB-1:0] wr_be2;

  ram_dp_be dut (
    .clk_i(clk), .rst_ni(rst_n), .ready_o(ready),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_be_i(wr_be),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
    .rd_valid_o(rd_valid), .err_o(err)
  );

  ram_dp_be #(.MEMORY_DEPTH(20)) dut20 (
    .clk_i(clk), .rst_ni(rst_n), .ready_o(ready2),
    .wr_en_i(wr_en2), .wr_addr_i(wr_addr2), .wr_data_i(wr_data2), .wr_be_i(wr_be2),
    .rd_en_i(rd_en2), .rd_addr_i(rd_addr2), .rd_data_o(rd_data2),
    .rd_valid_o(rd_valid2), .err_o(err2)
  );

  int vectors = 0;
  int miscompares = 0;
  int rd_accepted = 0;
  int rd_pulses = 0;
  logic [DW-1:0] model [32];
  logic [DW-1:0] exp_rd;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                          input logic [NB-1:0] be);
    logic [DW-1:0] w;
    w = old_w;
    for (int k = 0; k < NB; k++) if (be[k]) w[k*8 +: 8] = new_w[k*8 +: 8];
    return w;
  endfunction

  task automatic idle();
    wr_en = 0; rd_en = 0; wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
    wr_en2 = 0; rd_en2 = 0; wr_addr2 = '0; rd_addr2 = '0; wr_data2 = '0; wr_be2 = '0;
  endtask

  task automatic rand_req();
    wr_en   = 1'($urandom_range(0, 1));
    rd_en   = 1'($urandom_range(0, 1));
    wr_addr = AW'($urandom_range(0, 31));
    rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, 31));
    wr_data = $urandom();
    wr_be   = NB'($urandom());
  endtask

  // One ready-state cycle on the main instance, checked against the model.
  task automatic cycle(input string tag);
    logic [DW-1:0] exp_d;
    logic [DW-1:0] stored;
    exp_d  = exp_rd;
    stored = model[rd_addr];
    if (rd_en) begin
      exp_d = stored;
`ifdef RAM_BYPASS_EN
      if (wr_en && wr_addr == rd_addr) exp_d = merge(stored, wr_data, wr_be);
`endif
    end
    @(posedge clk); #1;
    if (wr_en) model[wr_addr] = merge(model[wr_addr], wr_data, wr_be);
    chk({tag, "_data"}, rd_data, exp_d);
    chk({tag, "_valid"}, DW'(rd_valid), DW'(rd_en));
    chk({tag, "_err"}, DW'(err), '0);
    if (rd_en) rd_accepted++;
    if (rd_valid) rd_pulses++;
    exp_rd = exp_d;
  endtask

  // Count edges until ready rises, with random requests that must be ignored.
  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!ready && n < 100) begin
      rand_req();
      @(posedge clk); #1;
      n++;
      chk({tag, "_sweep_valid"}, DW'(rd_valid), '0);
      chk({tag, "_sweep_err"}, DW'(err), '0);
    end
    chk({tag, "_ready_cycles"}, DW'(n), DW'(32));
    idle();
    for (int a = 0; a < 32; a++) model[a] = '0;
    exp_rd = '0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ready"}, DW'(ready), '0);
    chk({tag, "_rd_data"}, rd_data, '0);
    chk({tag, "_rd_valid"}, DW'(rd_valid), '0);
    chk({tag, "_err"}, DW'(err), '0);
  endtask

  initial begin
    idle();
    #12;
    chk_outputs_zero("reset");
    chk("reset_ready2", DW'(ready2), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_ready("boot");
    chk("boot_ready2", DW'(ready2), DW'(1));

    // Full read-back of the cleared array.
    for (int a = 0; a < 32; a++) begin
      rd_en = 1; rd_addr = AW'(a);
      cycle("clear_rd");
    end
    idle();

    // Byte-enable merge.
    wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; wr_be = 4'b1111; cycle("be_w1");
    wr_data = 32'h11223344; wr_be = 4'b0101; cycle("be_w2");
    wr_en = 0; wr_be = '0; rd_en = 1; rd_addr = 5; cycle("be_rd");
    chk("be_const", rd_data, 32'hDE22BE44);
    wr_en = 1; wr_addr = 6; wr_data = 32'h55555555; wr_be = 4'b0000; rd_addr = 6; cycle("be_noop");

    // Same-address read during write.
    wr_en = 1; wr_addr = 3; wr_data = 32'h12345678; wr_be = 4'hF; rd_en = 0; cycle("coll_pre");
    wr_data = 32'hAAAAAAAA; rd_en = 1; rd_addr = 3; cycle("coll");
`ifdef RAM_BYPASS_EN
    chk("coll_const", rd_data, 32'hAAAAAAAA);
`else
    chk("coll_const", rd_data, 32'h12345678);
`endif
    idle(); rd_en = 1; rd_addr = 3; cycle("coll_after");
    idle();

    // Out-of-range on the depth-20 instance.
    wr_en2 = 1; wr_addr2 = 7; wr_data2 = 32'hCAFEF00D; wr_be2 = 4'hF;
    @(posedge clk); #1; chk("oor_w7_err", DW'(err2), '0);
    wr_addr2 = 25; wr_data2 = 32'hFFFFFFFF;
    @(posedge clk); #1; chk("oor_w25_err", DW'(err2), DW'(1));
    wr_en2 = 0; rd_en2 = 1; rd_addr2 = 7;
    @(posedge clk); #1;
    chk("oor_rd7_data", rd_data2, 32'hCAFEF00D);
    chk("oor_rd7_err", DW'(err2), '0);
    rd_addr2 = 25;
    @(posedge clk); #1;
    chk("oor_rd25_data", rd_data2, '0);
    chk("oor_rd25_valid", DW'(rd_valid2), DW'(1));
    chk("oor_rd25_err", DW'(err2), DW'(1));
    rd_addr2 = 5;
    @(posedge clk); #1;
    chk("oor_rd5_data", rd_data2, '0);
    rd_en2 = 0;
    @(posedge clk); #1;
    chk("oor_idle_err", DW'(err2), '0);
    chk("oor_idle_valid", DW'(rd_valid2), '0);
    idle();

    // Random concurrent traffic.
    rd_accepted = 0; rd_pulses = 0;
    for (int i = 0; i < 1000; i++) begin
      rand_req();
      cycle("rand");
    end
    chk("rand_pulse_count", DW'(rd_pulses), DW'(rd_accepted));
    idle();

    // Reset mid-operation: outputs drop without a clock edge.
    rd_en = 1; rd_addr = 5; cycle("pre_rst");
    idle();
    #2 rst_n = 1'b0;
    #1 chk_outputs_zero("rst_midop");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset again at sweep cycle 10, hold 3 cycles.
    for (int i = 0; i < 10; i++) begin
      rand_req();
      @(posedge clk); #1;
      chk("sweep10_valid", DW'(rd_valid), '0);
    end
    chk("sweep10_not_ready", DW'(ready), '0);
    rst_n = 1'b0;
    #1 chk_outputs_zero("rst_midsweep");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_ready("resweep");

    for (int i = 0; i < 8; i++) begin
      rd_en = 1; rd_addr = AW'($urandom_range(0, 31));
      cycle("resweep_rd");
    end
    wr_en = 1; wr_addr = 9; wr_data = 32'h0BADF00D; wr_be = 4'b1010; rd_en = 0; cycle("post_w");
    idle(); rd_en = 1; rd_addr = 9; cycle("post_rd");
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
